framebuffer_write_arbiter: RTL
==============================

FRAMEBUFFER_WRITE_ARBITER -- requirements
Module: framebuffer_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of pixel-write requesters.
REQ-002 Parameter ADDR_W, default 19: framebuffer address width.
REQ-003 Parameter DATA_W, default 4: pixel colour-index width.
REQ-004 clock  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fb_resetting  input  1  back-buffer clear in progress; while high, no write SHALL be granted.
REQ-007 req_valid  input  NUM_REQ  per-requester pixel-pair valid.
REQ-008 req_lock  input  NUM_REQ  per-requester burst hold; keeps ownership after the current transfer.
REQ-009 req_addr1, req_addr2  input  NUM_REQ*ADDR_W each  flattened pixel addresses, requester i at slice [i*ADDR_W +: ADDR_W].
REQ-010 req_data1, req_data2  input  NUM_REQ*DATA_W each  flattened pixel data.
REQ-011 req_en1, req_en2  input  NUM_REQ each  per-pixel write enable within the pair.
REQ-012 req_ready  output  NUM_REQ  one-hot or zero; transfer occurs when req_valid[i] & req_ready[i].
REQ-013 addr_wr1, addr_wr2  output  ADDR_W each  registered write addresses to the framebuffer write ports.
REQ-014 data_wr1, data_wr2  output  DATA_W each  registered write data.
REQ-015 wr1_en, wr2_en  output  1 each  registered write strobes.
REQ-016 owner  output  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-017 drop_count  output  16  count of pixels suppressed by the range check.

Function
REQ-018 FSM states: IDLE (no owner), OWNED (owner holds lock), BLOCKED (fb_resetting high).
REQ-019 IDLE: req_ready SHALL select the first valid requester in round-robin order, starting at rr_ptr.
REQ-020 A transfer from requester i with req_lock[i] low SHALL set rr_ptr to (i+1) mod NUM_REQ and remain in IDLE.
REQ-021 A transfer with req_lock[i] high SHALL move to OWNED with owner=i.
REQ-022 OWNED: only req_ready[owner] MAY assert; on a cycle with req_lock[owner] low (transfer or not), the FSM SHALL return to IDLE and rr_ptr SHALL become owner+1 mod NUM_REQ.
REQ-023 When fb_resetting is high, req_ready SHALL be all-zero in the same cycle, and the FSM SHALL enter BLOCKED, remembering whether an owner was held.
REQ-024 On fb_resetting falling, BLOCKED SHALL return to OWNED (same owner) if one was held, else to IDLE.
REQ-025 Write latency SHALL be exactly one cycle: on transfer at cycle N, the addr_wr*/data_wr*/wr*_en outputs SHALL carry that pair at cycle N+1; in cycles with no transfer, wr1_en and wr2_en SHALL be 0.
REQ-026 A pixel with address >= FRAMEBUFFER_SIZE SHALL have its wr*_en forced to 0, and drop_count SHALL increment by one per suppressed pixel (0, 1 or 2 per cycle), saturating at 16'hFFFF.
REQ-027 A pixel with req_en*=0 SHALL be neither written nor counted as dropped.
REQ-028 The arbiter SHALL NOT combinationally depend req_valid on req_ready; a requester MAY hold valid indefinitely.

Reset
REQ-029 On reset, the FSM SHALL enter IDLE with rr_ptr=0 and owner=0.
REQ-030 On reset, req_ready, wr1_en, wr2_en, addr_wr*, data_wr* and drop_count SHALL all be 0.
REQ-031 Reset mid-burst SHALL release ownership, and the in-flight registered write SHALL be cancelled (enables 0 in the next cycle).

Structure
REQ-032 FRAMEBUFFER_SIZE, ADDR_W/DATA_W defaults and the state enum SHALL reside in the shared params package/header.
REQ-033 The round-robin priority pick SHALL be a sub-module rr_pick (inputs request vector and pointer; outputs one-hot grant and index).

Verification
REQ-034 The bench SHALL cover: all 3 valid, no lock, 6 cycles -> grants 0,1,2,0,1,2, with writes appearing one cycle after each grant.
REQ-035 The bench SHALL cover: req 1 locks for 4 transfers while req 0 and req 2 are valid -> owner=1 for 4 transfers, then req 2 is granted next.
REQ-036 The bench SHALL cover: fb_resetting high for 10 cycles mid-burst of req 0 -> req_ready=0 and wr*_en=0 throughout; then req 0 resumes first.
REQ-037 The bench SHALL cover: addr1=307199, addr2=307200 with FRAMEBUFFER_SIZE=307200 -> wr1_en=1, wr2_en=0, drop_count=1.
REQ-038 The bench SHALL cover: reset asserted the cycle after a transfer -> wr*_en=0 next cycle, rr_ptr=0, and req 0 is granted first.
REQ-039 The bench SHALL cover: drop_count preloaded by 65535 drops, then 2 more drops -> drop_count holds at 16'hFFFF.

Source files
------------

// File: rtl/framebuffer_write_arbiter_pkg.sv
// Shared constants, FSM encoding and index helper for the framebuffer write arbiter.
// Pulled in by the arbiter top and by its round-robin picker.
package framebuffer_write_arbiter_pkg;

  localparam int unsigned FRAMEBUFFER_SIZE = 307200;  // 640x480 pixels
  localparam int ADDR_W_DEFAULT = 19;
  localparam int DATA_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_BLOCKED = 2'd2
  } arb_state_t;

  // (a + b) mod n, assuming both a and b are already below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/framebuffer_write_arbiter_rr_pick.sv
// Round-robin priority pick: the first set bit of req, scanning upward from ptr
// and wrapping around. Produces a one-hot grant and the index of that grant.
module rr_pick
  import framebuffer_write_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IDX_W'(wrap_add(int'(ptr), k, N));
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Arbitrates pixel-pair write requests onto the two framebuffer write ports,
// with round-robin fairness, burst locking, clear-time blocking and a range check.
module framebuffer_write_arbiter
  import framebuffer_write_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = 3,
  parameter int  ADDR_W  = ADDR_W_DEFAULT,
  parameter int  DATA_W  = DATA_W_DEFAULT,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fb_resetting,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr1,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr2,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data1,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data2,
  input  logic [NUM_REQ-1:0]         req_en1,
  input  logic [NUM_REQ-1:0]         req_en2,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ADDR_W-1:0]          addr_wr1,
  output logic [ADDR_W-1:0]          addr_wr2,
  output logic [DATA_W-1:0]          data_wr1,
  output logic [DATA_W-1:0]          data_wr2,
  output logic                       wr1_en,
  output logic                       wr2_en,
  output logic [IDX_W-1:0]           owner,
  output logic [15:0]                drop_count,
  output arb_state_t                 state_dbg,
  output logic [IDX_W-1:0]           rr_ptr_dbg
);

  localparam logic [63:0] FB_SIZE64 = 64'(FRAMEBUFFER_SIZE);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             held_q, held_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               xfer;
  logic [IDX_W-1:0]   xfer_idx;

  logic [ADDR_W-1:0] sel_addr1, sel_addr2;
  logic [DATA_W-1:0] sel_data1, sel_data2;
  logic              sel_en1, sel_en2;
  logic              wr1_go, wr2_go, drop1, drop2;
  logic [16:0]       drop_sum;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Handshake: a pair moves when req_valid[i] & req_ready[i] at a rising edge.
  // Ready may look at valid; a requester must not gate valid on ready, and may
  // hold valid (with stable payload) for as long as it likes.
  always_comb begin
    req_ready = '0;
    if (!reset && !fb_resetting) begin
      case (state_q)
        ST_IDLE:  req_ready = pick_grant;
        ST_OWNED: req_ready[owner_q] = 1'b1;
        default:  req_ready = '0;
      endcase
    end
  end

  assign xfer     = |(req_valid & req_ready);
  assign xfer_idx = (state_q == ST_OWNED) ? owner_q : pick_idx;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    held_d   = held_q;
    if (fb_resetting) begin
      state_d = ST_BLOCKED;
      if (state_q != ST_BLOCKED) held_d = (state_q == ST_OWNED);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            owner_d = pick_idx;
            if (req_lock[pick_idx]) state_d = ST_OWNED;
            else rr_ptr_d = inc_idx(pick_idx);
          end
        end
        ST_OWNED: begin
          if (!req_lock[owner_q]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = inc_idx(owner_q);
          end
        end
        default: begin
          state_d = held_q ? ST_OWNED : ST_IDLE;
          held_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    sel_addr1 = '0;
    sel_addr2 = '0;
    sel_data1 = '0;
    sel_data2 = '0;
    sel_en1   = 1'b0;
    sel_en2   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer_idx == IDX_W'(i)) begin
        sel_addr1 = req_addr1[i*ADDR_W +: ADDR_W];
        sel_addr2 = req_addr2[i*ADDR_W +: ADDR_W];
        sel_data1 = req_data1[i*DATA_W +: DATA_W];
        sel_data2 = req_data2[i*DATA_W +: DATA_W];
        sel_en1   = req_en1[i];
        sel_en2   = req_en2[i];
      end
    end
  end

  // Disabled pixels are neither written nor counted; enabled out-of-range ones are dropped.
  assign wr1_go   = xfer & sel_en1 & (64'(sel_addr1) < FB_SIZE64);
  assign wr2_go   = xfer & sel_en2 & (64'(sel_addr2) < FB_SIZE64);
  assign drop1    = xfer & sel_en1 & ~wr1_go;
  assign drop2    = xfer & sel_en2 & ~wr2_go;
  assign drop_sum = {1'b0, drop_count} + 17'(drop1) + 17'(drop2);

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_wr1   <= '0;
      addr_wr2   <= '0;
      data_wr1   <= '0;
      data_wr2   <= '0;
      wr1_en     <= 1'b0;
      wr2_en     <= 1'b0;
      drop_count <= '0;
    end else begin
      wr1_en     <= wr1_go;
      wr2_en     <= wr2_go;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (xfer) begin
        addr_wr1 <= sel_addr1;
        addr_wr2 <= sel_addr2;
        data_wr1 <= sel_data1;
        data_wr2 <= sel_data2;
      end
    end
  end

  assign owner      = owner_q;
  assign state_dbg  = state_q;
  assign rr_ptr_dbg = rr_ptr_q;

endmodule
